// File: rtl/map_sched_pkg.sv
// Shared types for the Map probe scheduler: coordinate width, probe directions,
// FSM states, the in-flight probe tag, and the probe coordinate helper.
package map_sched_pkg;

    localparam int COORD_W = 10;
    localparam int CHAR_W  = 4;

    typedef logic [CHAR_W-1:0] char_idx_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        ISSUE = 2'd2,
        DRAIN = 2'd3
    } sched_state_e;

    typedef struct packed {
        logic      valid;
        char_idx_t idx;
        dir_e      dir;
    } probe_tag_t;

    localparam probe_tag_t TAG_NONE = '{valid: 1'b0, idx: '0, dir: DIR_UP};

    // Edge probe point around a character center; 10-bit wraparound is intended.
    function automatic logic [2*COORD_W-1:0] probe_point(
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] y,
        input logic [COORD_W-1:0] x_size,
        input logic [COORD_W-1:0] y_size,
        input dir_e               dir
    );
        logic [COORD_W-1:0] px;
        logic [COORD_W-1:0] py;
        px = x;
        py = y;
        case (dir)
            DIR_UP:   py = y - y_size;
            DIR_DOWN: py = y + y_size;
            DIR_LEFT: px = x - x_size;
            default:  px = x + x_size;
        endcase
        return {px, py};
    endfunction

endpackage

// File: rtl/map_probe_scheduler_if.sv
// Shared Map wall-lookup port: the scheduler is the master, the Map is the slave.
interface map_probe_scheduler_if;
    import map_sched_pkg::*;

    logic               map_rd;
    logic [COORD_W-1:0] map_x;
    logic [COORD_W-1:0] map_y;
    logic               map_is_wall;
    logic [COORD_W-1:0] map_bias_x;
    logic [COORD_W-1:0] map_bias_y;

    modport master (
        output map_rd, map_x, map_y,
        input  map_is_wall, map_bias_x, map_bias_y
    );

    modport slave (
        input  map_rd, map_x, map_y,
        output map_is_wall, map_bias_x, map_bias_y
    );

endinterface

// File: rtl/map_tag_pipe.sv
// MAP_LAT-deep delay line carrying probe tags alongside the Map read latency,
// cleared by the asynchronous reset so no stale return is ever committed.
module map_tag_pipe
    import map_sched_pkg::*;
#(
    parameter int MAP_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  probe_tag_t tag_in,
    output probe_tag_t tag_out
);

    probe_tag_t stage_p [MAP_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAP_LAT; i++) stage_p[i] <= TAG_NONE;
        end else begin
            stage_p[0] <= tag_in;
            for (int i = 1; i < MAP_LAT; i++) stage_p[i] <= stage_p[i-1];
        end
    end

    assign tag_out = stage_p[MAP_LAT-1];

endmodule

// File: rtl/map_probe_scheduler.sv
// Shares one Map lookup port among NUM_CHAR characters, four edge probes each per frame.
// Optional MAP_SCHED_RR_EN: rotate the service start index every serviced frame.
module map_probe_scheduler
    import map_sched_pkg::*;
#(
    parameter int                 NUM_CHAR = 2,
    parameter logic [COORD_W-1:0] X_SIZE   = 10'd30,
    parameter logic [COORD_W-1:0] Y_SIZE   = 10'd30,
    parameter int                 MAP_LAT  = 1
) (
    input  logic                            Clk,
    input  logic                            Reset_n,
    input  logic                            frame_clk,
    input  logic [NUM_CHAR-1:0]             char_req,
    input  logic [NUM_CHAR*COORD_W-1:0]     char_x,
    input  logic [NUM_CHAR*COORD_W-1:0]     char_y,
    map_probe_scheduler_if.master           map,
    output logic [NUM_CHAR*4-1:0]           res_wall,
    output logic [NUM_CHAR*4*COORD_W-1:0]   res_bias,
    output logic [NUM_CHAR-1:0]             res_valid,
    output logic                            busy,
    output logic                            overrun
);

    sched_state_e       state, state_n;
    logic               frame_d, frame_rise;
    char_idx_t          start_idx;
    char_idx_t          order_n [NUM_CHAR];
    char_idx_t          order_q [NUM_CHAR];
    char_idx_t          last_slot_n, last_slot_q;
    logic               any_req;
    logic [COORD_W-1:0] x_s [NUM_CHAR];
    logic [COORD_W-1:0] y_s [NUM_CHAR];
    char_idx_t          slot;
    dir_e               dir;
    logic [2:0]         drain_cnt;
    char_idx_t          cur_char;
    logic [COORD_W-1:0] cur_x, cur_y, probe_x, probe_y;
    logic [COORD_W-1:0] hold_x, hold_y;
    logic               issue_last;
    probe_tag_t         tag_in, tag_out;
    logic [3:0]              wall_q [NUM_CHAR];
    logic [3:0][COORD_W-1:0] bias_q [NUM_CHAR];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_d    <= 1'b0;
            frame_rise <= 1'b0;
        end else begin
            frame_d    <= frame_clk;
            frame_rise <= frame_clk & ~frame_d;
        end
    end

`ifdef MAP_SCHED_RR_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            start_idx <= '0;
        end else if (state == LATCH) begin
            start_idx <= (start_idx == char_idx_t'(NUM_CHAR-1)) ? '0 : start_idx + char_idx_t'(1);
        end
    end
`else
    assign start_idx = '0;
`endif

    // Compact the requesters into a service list beginning at start_idx.
    always_comb begin
        int cnt;
        cnt = 0;
        for (int j = 0; j < NUM_CHAR; j++) order_n[j] = '0;
        for (int i = 0; i < NUM_CHAR; i++) begin
            for (int c = 0; c < NUM_CHAR; c++) begin
                if (c == (int'(start_idx) + i) % NUM_CHAR && char_req[c]) begin
                    for (int j = 0; j < NUM_CHAR; j++) begin
                        if (j == cnt) order_n[j] = char_idx_t'(c);
                    end
                    cnt = cnt + 1;
                end
            end
        end
        any_req     = (cnt != 0);
        last_slot_n = char_idx_t'(cnt - 1);
    end

    always_ff @(posedge Clk) begin
        if (state == LATCH) begin
            for (int k = 0; k < NUM_CHAR; k++) begin
                x_s[k] <= char_x[k*COORD_W +: COORD_W];
                y_s[k] <= char_y[k*COORD_W +: COORD_W];
            end
            order_q     <= order_n;
            last_slot_q <= last_slot_n;
        end
    end

    always_comb begin
        cur_char = '0;
        cur_x    = '0;
        cur_y    = '0;
        for (int i = 0; i < NUM_CHAR; i++) begin
            if (slot == char_idx_t'(i)) cur_char = order_q[i];
        end
        for (int k = 0; k < NUM_CHAR; k++) begin
            if (cur_char == char_idx_t'(k)) begin
                cur_x = x_s[k];
                cur_y = y_s[k];
            end
        end
        {probe_x, probe_y} = probe_point(cur_x, cur_y, X_SIZE, Y_SIZE, dir);
    end

    assign map.map_rd = (state == ISSUE);
    assign map.map_x  = map.map_rd ? probe_x : hold_x;
    assign map.map_y  = map.map_rd ? probe_y : hold_y;
    assign issue_last = (state == ISSUE) && (slot == last_slot_q) && (dir == DIR_RIGHT);
    assign busy       = (state != IDLE);
    assign overrun    = frame_rise & busy;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (frame_rise) state_n = LATCH;
            LATCH:   state_n = any_req ? ISSUE : IDLE;
            ISSUE:   if (issue_last) state_n = DRAIN;
            default: if (drain_cnt == 3'(MAP_LAT-1)) state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            slot      <= '0;
            dir       <= DIR_UP;
            drain_cnt <= '0;
            hold_x    <= '0;
            hold_y    <= '0;
        end else begin
            state <= state_n;
            if (state == LATCH) begin
                slot <= '0;
                dir  <= DIR_UP;
            end else if (state == ISSUE) begin
                dir <= dir_e'(dir + 2'd1);
                if (dir == DIR_RIGHT) slot <= slot + char_idx_t'(1);
            end
            drain_cnt <= (state == DRAIN) ? drain_cnt + 3'd1 : 3'd0;
            if (map.map_rd) begin
                hold_x <= probe_x;
                hold_y <= probe_y;
            end
        end
    end

    // Issue stage -> return stage: tags ride alongside the Map latency.
    assign tag_in = '{valid: (state == ISSUE), idx: cur_char, dir: dir};

    map_tag_pipe #(.MAP_LAT(MAP_LAT)) u_tag_pipe (
        .clk     (Clk),
        .rst_n   (Reset_n),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int k = 0; k < NUM_CHAR; k++) begin
                wall_q[k] <= '0;
                bias_q[k] <= '0;
            end
            res_valid <= '0;
        end else begin
            res_valid <= '0;
            if (tag_out.valid) begin
                for (int k = 0; k < NUM_CHAR; k++) begin
                    if (tag_out.idx == char_idx_t'(k)) begin
                        wall_q[k][tag_out.dir] <= map.map_is_wall;
                        bias_q[k][tag_out.dir] <= (tag_out.dir == DIR_UP || tag_out.dir == DIR_DOWN)
                                                  ? map.map_bias_y : map.map_bias_x;
                        if (tag_out.dir == DIR_RIGHT) res_valid[k] <= 1'b1;
                    end
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_CHAR; k++) begin : g_flat
        assign res_wall[4*k +: 4]                 = wall_q[k];
        assign res_bias[4*COORD_W*k +: 4*COORD_W] = bias_q[k];
    end

endmodule
